// File: rtl/prog_loader_if.sv
// Boot loader bus bundle: byte stream in, instruction-memory write port and CPU control out.
interface prog_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] instr_addr2;
  logic [15:0] instr_data2;
  logic        instr_wen2;
  logic        cpu_hold;
  logic        cpu_start;
  logic [15:0] start_pc;
  logic        busy;
  logic        done;
  logic        error;

  // Loader side: consumes the stream, drives memory writes and CPU control
  modport master (
    input  rx_data, rx_valid,
    output rx_ready, instr_addr2, instr_data2, instr_wen2,
           cpu_hold, cpu_start, start_pc, busy, done, error
  );

  // Environment side: stream source, memory and CPU
  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, instr_addr2, instr_data2, instr_wen2,
           cpu_hold, cpu_start, start_pc, busy, done, error
  );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: parses a framed byte stream, writes 16-bit words into
// instruction memory and releases the CPU once the image checksum verifies.
module prog_loader #(
  parameter int unsigned TIMEOUT   = 1024,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input logic         clk,
  input logic         reset,
  prog_loader_if.master bus
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, HDR_ADDR, HDR_LEN, LOAD, CHECK, DONE, ERR
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    hi_q, hi_d;
  logic          ph_q, ph_d;            // 1 = high byte held, next byte completes a word
  logic [15:0]   addr_q, addr_d;        // next write address
  logic [15:0]   rem_q, rem_d;          // data words still expected
  logic [15:0]   csum_q, csum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [TW-1:0] tmo_inc;

  logic          rx_ready_q, rx_ready_d;
  logic          wen_q, wen_d;
  logic [15:0]   waddr_q, waddr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          hold_q, hold_d;
  logic          start_q, start_d;
  logic [15:0]   pc_q, pc_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic          accept;
  logic          in_frame;
  logic          word_done;
  logic [15:0]   word;

  assign accept    = bus.rx_valid & rx_ready_q;
  assign in_frame  = (state_q == HDR_ADDR) || (state_q == HDR_LEN) ||
                     (state_q == LOAD)     || (state_q == CHECK);
  assign word_done = accept & ph_q & in_frame;
  assign word      = {hi_q, bus.rx_data};
  assign tmo_inc   = TW'(tmo_q + TW'(1));

  // Next-state, word assembly, checksum, timeout and registered-output values
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    ph_d    = ph_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    csum_d  = csum_q;
    tmo_d   = tmo_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    pc_d    = pc_q;

    if (in_frame) begin
      if (accept) begin
        tmo_d = '0;
        if (!ph_q) begin
          hi_d = bus.rx_data;
          ph_d = 1'b1;
        end else begin
          ph_d = 1'b0;
        end
      end else begin
        tmo_d = tmo_inc;
        if (tmo_inc == TW'(TIMEOUT)) state_d = ERR;
      end
    end

    case (state_q)
      IDLE: begin
        if (accept && (bus.rx_data == SYNC_BYTE)) begin
          state_d = HDR_ADDR;
          ph_d    = 1'b0;
          tmo_d   = '0;
          csum_d  = '0;
        end
      end
      HDR_ADDR: begin
        if (word_done) begin
          addr_d  = word;
          pc_d    = word;
          state_d = HDR_LEN;
        end
      end
      HDR_LEN: begin
        if (word_done) begin
          rem_d   = word;
          csum_d  = '0;
          state_d = (word == 16'h0000) ? CHECK : LOAD;
        end
      end
      LOAD: begin
        if (word_done) begin
          wen_d   = 1'b1;
          waddr_d = addr_q;
          wdata_d = word;
          addr_d  = 16'(addr_q + 16'd1);
          csum_d  = csum_q ^ word;
          rem_d   = 16'(rem_q - 16'd1);
          if (rem_q == 16'd1) state_d = CHECK;
        end
      end
      CHECK: begin
        if (word_done) state_d = (word == csum_q) ? DONE : ERR;
      end
      default: ;
    endcase

    rx_ready_d = (state_d != DONE) && (state_d != ERR);
    busy_d     = (state_d == HDR_ADDR) || (state_d == HDR_LEN) ||
                 (state_d == LOAD)     || (state_d == CHECK);
    done_d     = (state_d == DONE);
    error_d    = (state_d == ERR);
    hold_d     = (state_d != DONE);
    start_d    = (state_d == DONE) && (state_q != DONE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      hi_q       <= '0;
      ph_q       <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      csum_q     <= '0;
      tmo_q      <= '0;
      rx_ready_q <= 1'b0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      hold_q     <= 1'b1;
      start_q    <= 1'b0;
      pc_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      ph_q       <= ph_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      csum_q     <= csum_d;
      tmo_q      <= tmo_d;
      rx_ready_q <= rx_ready_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      start_q    <= start_d;
      pc_q       <= pc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign bus.rx_ready    = rx_ready_q;
  assign bus.instr_wen2  = wen_q;
  assign bus.instr_addr2 = waddr_q;
  assign bus.instr_data2 = wdata_q;
  assign bus.cpu_hold    = hold_q;
  assign bus.cpu_start   = start_q;
  assign bus.start_pc    = pc_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;

endmodule
